// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, bit-period arithmetic and parameter checks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int c_ns_per_s = 1_000_000_000;

    // Both periods are truncated to whole ns before dividing, matching the receiver.
    function automatic int calc_cycles_per_bit(input int bit_rate, input int clk_hz);
        int bit_p;
        int clk_p;
        bit_p = c_ns_per_s / bit_rate;
        clk_p = c_ns_per_s / clk_hz;
        return bit_p / clk_p;
    endfunction

    function automatic bit params_legal(input int payload_bits, input int stop_bits,
                                        input int cycles_per_bit);
        return (payload_bits >= 5) && (payload_bits <= 9) &&
               ((stop_bits == 1) || (stop_bits == 2)) && (cycles_per_bit >= 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Front-end handshake and serial-line bundle of the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    uart_tx_en;
    logic                    uart_tx_valid;
    logic                    uart_tx_ready;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_tx_busy;
    logic                    uart_txd;
    logic                    clk_req;

    modport master (
        output uart_tx_en, uart_tx_valid, uart_tx_data,
        input  uart_tx_ready, uart_tx_busy, uart_txd, clk_req
    );

    modport slave (
        input  uart_tx_en, uart_tx_valid, uart_tx_data,
        output uart_tx_ready, uart_tx_busy, uart_txd, clk_req
    );
endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Counts CYCLES_PER_BIT clocks, flags the last cycle of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CYCLES_PER_BIT = 434,
    parameter int COUNT_REG_LEN  = 1 + $clog2(CYCLES_PER_BIT)
) (
    input  wire  clk,
    input  wire  resetn,
    input  wire  i_clear,
    output logic o_bit_end
);
    localparam logic [COUNT_REG_LEN-1:0] c_last = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);

    logic [COUNT_REG_LEN-1:0] r_count;

    assign o_bit_end = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (!resetn || i_clear || o_bit_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + COUNT_REG_LEN'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, one frame (start, LSB-first data, stop) per handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 115200,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  wire        clk,
    input  wire        resetn,
    uart_tx_if.slave   bus
);
    localparam int CYCLES_PER_BIT = calc_cycles_per_bit(BIT_RATE, CLK_HZ);
    localparam int COUNT_REG_LEN  = 1 + $clog2(CYCLES_PER_BIT);

    localparam logic [3:0] c_last_data = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);

    if (!params_legal(PAYLOAD_BITS, STOP_BITS, CYCLES_PER_BIT)) begin : g_param_check
        $error("uart_tx: PAYLOAD_BITS, STOP_BITS or bit timing out of range");
    end

    uart_state_t             r_state;
    uart_state_t             w_state_next;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [PAYLOAD_BITS-1:0] w_shift_next;
    logic [3:0]              r_bit_cnt;
    logic [3:0]              w_bit_cnt_next;
    logic                    r_txd;
    logic                    w_txd_next;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_bit_end;
    logic                    w_timer_clear;

    assign w_ready       = resetn && bus.uart_tx_en && (r_state == IDLE);
    assign w_accept      = bus.uart_tx_valid && w_ready;
    assign w_timer_clear = (r_state == IDLE) || !bus.uart_tx_en;

    assign bus.uart_tx_ready = w_ready;
    assign bus.uart_tx_busy  = (r_state != IDLE);
    assign bus.clk_req       = (r_state != IDLE) || bus.uart_tx_valid;
    assign bus.uart_txd      = r_txd;

    uart_bit_timer #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT),
        .COUNT_REG_LEN  (COUNT_REG_LEN)
    ) u_bit_timer (
        .clk       (clk),
        .resetn    (resetn),
        .i_clear   (w_timer_clear),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_txd     <= w_txd_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_txd_next     = 1'b1;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next   = START;
                    w_shift_next   = bus.uart_tx_data;
                    w_bit_cnt_next = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == c_last_data) begin
                        w_state_next   = STOP;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_last_stop) begin
                        w_state_next = IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Dropping enable abandons the frame outright; it is never resumed.
        if (!bus.uart_tx_en) begin
            w_state_next   = IDLE;
            w_bit_cnt_next = '0;
        end

        // The line register is loaded with the level belonging to the next state.
        if (w_state_next == START) begin
            w_txd_next = 1'b0;
        end else if (w_state_next == DATA) begin
            w_txd_next = w_shift_next[0];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx, 8N1 and 7N2 instances at 10 clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
    localparam int C   = 10;
    localparam int F_A = (1 + 8 + 1) * C;
    localparam int F_B = (1 + 7 + 2) * C;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if #(.PAYLOAD_BITS(8)) if_a();
    uart_tx_if #(.PAYLOAD_BITS(7)) if_b();

    uart_tx #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1))
        dut_a (.clk(clk), .resetn(resetn), .bus(if_a.slave));
    uart_tx #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(7), .STOP_BITS(2))
        dut_b (.clk(clk), .resetn(resetn), .bus(if_b.slave));

    typedef struct {
        logic [8:0] data;
        int         start;
        int         len;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   mon_busy_a = 0;
    int   mon_busy_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic line(input int sel);
        return (sel != 0) ? if_b.uart_txd : if_a.uart_txd;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel != 0) ? if_b.uart_tx_ready : if_a.uart_tx_ready;
    endfunction

    task automatic set_valid(input int sel, input logic v, input logic [8:0] d);
        if (sel != 0) begin
            if_b.uart_tx_valid = v;
            if_b.uart_tx_data  = d[6:0];
        end else begin
            if_a.uart_tx_valid = v;
            if_a.uart_tx_data  = d[7:0];
        end
    endtask

    // Entered 1ns after a posedge; returns 1ns after the posedge following acceptance, valid left high.
    task automatic send(input int sel, input logic [8:0] d, input int len, output int t);
        bit   done;
        exp_t e;
        done = 1'b0;
        t    = -1;
        set_valid(sel, 1'b1, d);
        for (int i = 0; i < 2000 && !done; i++) begin
            #1;
            if (rdy(sel)) begin
                t       = cyc;
                done    = 1'b1;
                e.data  = d;
                e.start = t + 1;
                e.len   = len;
                if (sel != 0) q_b.push_back(e);
                else q_a.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("accept_%0d_%0h", sel, d), 32'(done), 32'd1);
    endtask

    // Captures a whole frame window from its start bit and compares each cycle with the expected line.
    task automatic monitor(input int sel);
        exp_t       e;
        int         p, f, errs, bi;
        bit         have;
        logic       b, want;
        logic [8:0] got;
        p = (sel != 0) ? 7 : 8;
        f = (sel != 0) ? F_B : F_A;
        forever begin
            @(negedge clk);
            if (line(sel) === 1'b0) begin
                if (sel != 0) mon_busy_b = 1; else mon_busy_a = 1;
                have = ((sel != 0) ? q_b.size() : q_a.size()) > 0;
                check($sformatf("frame_expected_%0d", sel), 32'(have), 32'd1);
                if (!have) begin
                    repeat (f - 1) @(negedge clk);
                end else begin
                    e = (sel != 0) ? q_b.pop_front() : q_a.pop_front();
                    check($sformatf("start_cycle_%0d_%0h", sel, e.data), cyc, e.start);
                    errs = 0;
                    got  = '0;
                    for (int k = 0; k < f; k++) begin
                        if (k > 0) @(negedge clk);
                        b  = line(sel);
                        bi = k / C;
                        if (bi == 0) want = 1'b0;
                        else if (bi <= p) want = e.data[bi-1];
                        else want = 1'b1;
                        if (k >= e.len) want = 1'b1;
                        if (b !== want) errs++;
                        if ((k % C) == (C / 2) && bi >= 1 && bi <= p) got[bi-1] = b;
                    end
                    check($sformatf("wave_errs_%0d_%0h", sel, e.data), errs, 0);
                    if (e.len == f) check($sformatf("frame_data_%0d", sel), 32'(got), 32'(e.data));
                end
                if (sel != 0) mon_busy_b = 0; else mon_busy_a = 0;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        int t, t1, t2, errs;
        if_a.uart_tx_en = 1'b1; if_a.uart_tx_valid = 1'b0; if_a.uart_tx_data = '0;
        if_b.uart_tx_en = 1'b1; if_b.uart_tx_valid = 1'b0; if_b.uart_tx_data = '0;

        // Reset held three cycles with enable high
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd_a",   32'(if_a.uart_txd),      32'd1);
        check("rst_busy_a",  32'(if_a.uart_tx_busy),  32'd0);
        check("rst_ready_a", 32'(if_a.uart_tx_ready), 32'd0);
        check("rst_txd_b",   32'(if_b.uart_txd),      32'd1);
        resetn = 1'b1;
        #1;
        check("release_ready_a", 32'(if_a.uart_tx_ready), 32'd1);

        // Single 0xA5 frame, busy window and ready afterwards
        @(posedge clk); #1;
        send(0, 9'h0A5, F_A, t);
        set_valid(0, 1'b0, 9'h0);
        check("clk_req_busy", 32'(if_a.clk_req), 32'd1);
        errs = 0;
        for (int i = 0; i < F_A; i++) begin
            if (if_a.uart_tx_busy !== 1'b1) errs++;
            @(posedge clk); #1;
        end
        check("a5_busy_errs", errs, 0);
        check("a5_ready_end", 32'(if_a.uart_tx_ready), 32'd1);
        check("a5_busy_end",  32'(if_a.uart_tx_busy),  32'd0);
        check("clk_req_idle", 32'(if_a.clk_req),       32'd0);

        // Back-to-back with valid held: 0x00 then 0xFF
        @(posedge clk); #1;
        send(0, 9'h000, F_A, t1);
        send(0, 9'h0FF, F_A, t2);
        set_valid(0, 1'b0, 9'h0);
        check("b2b_gap", t2 - t1, F_A + 1);
        repeat (F_A + 5) @(posedge clk); #1;

        // Valid pulse with 0x3C during data bit 2 is ignored
        send(0, 9'h096, F_A, t);
        set_valid(0, 1'b0, 9'h0);
        repeat (34) @(posedge clk); #1;
        set_valid(0, 1'b1, 9'h03C);
        #1;
        check("busy_ready_low", 32'(if_a.uart_tx_ready), 32'd0);
        @(posedge clk); #1;
        set_valid(0, 1'b0, 9'h0);
        repeat (F_A) @(posedge clk); #1;
        check("busy_pulse_idle", 32'(if_a.uart_tx_busy), 32'd0);

        // Enable drop during data bit 3 of 0x33, then a fresh 0x5A frame
        send(0, 9'h033, 45, t);
        set_valid(0, 1'b0, 9'h0);
        repeat (44) @(posedge clk); #1;
        if_a.uart_tx_en = 1'b0;
        @(posedge clk); #1;
        check("endrop_txd",   32'(if_a.uart_txd),      32'd1);
        check("endrop_busy",  32'(if_a.uart_tx_busy),  32'd0);
        check("endrop_ready", 32'(if_a.uart_tx_ready), 32'd0);
        repeat (70) @(posedge clk); #1;
        check("endrop_ready_held", 32'(if_a.uart_tx_ready), 32'd0);
        if_a.uart_tx_en = 1'b1;
        #1;
        check("en_back_ready", 32'(if_a.uart_tx_ready), 32'd1);
        @(posedge clk); #1;
        send(0, 9'h05A, F_A, t);
        set_valid(0, 1'b0, 9'h0);
        repeat (F_A + 5) @(posedge clk); #1;

        // Reset during the start bit of 0x0F
        send(0, 9'h00F, 5, t);
        set_valid(0, 1'b0, 9'h0);
        repeat (4) @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        check("midrst_txd",   32'(if_a.uart_txd),      32'd1);
        check("midrst_busy",  32'(if_a.uart_tx_busy),  32'd0);
        check("midrst_ready", 32'(if_a.uart_tx_ready), 32'd0);
        resetn = 1'b1;
        repeat (F_A + 5) @(posedge clk); #1;

        // 7 data bits, 2 stop bits: 0x55
        send(1, 9'h055, F_B, t);
        set_valid(1, 1'b0, 9'h0);
        errs = 0;
        for (int i = 0; i < F_B; i++) begin
            if (if_b.uart_tx_busy !== 1'b1) errs++;
            @(posedge clk); #1;
        end
        check("b_busy_errs", errs, 0);
        check("b_ready_end", 32'(if_b.uart_tx_ready), 32'd1);
        check("b_busy_end",  32'(if_b.uart_tx_busy),  32'd0);

        for (int i = 0; i < 500 && (q_a.size() != 0 || q_b.size() != 0 ||
                                     mon_busy_a != 0 || mon_busy_b != 0); i++) begin
            @(posedge clk);
        end
        check("drain", q_a.size() + q_b.size() + mon_busy_a + mon_busy_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
